// File: rtl/pwm_4ip_s_axi_slave.sv
// AXI4-Lite register slave for pwm_4ip: four 32-bit duty registers and four
// PWM channels driven from one shared free-running counter. Duty changes take
// effect only at the period wrap, so a channel never emits a truncated or
// stretched pulse.
module pwm_4ip_s_axi_slave #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
    parameter int unsigned C_PWM_WIDTH        = 8,
    parameter int unsigned C_PWM_PRESCALE     = 1
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [3:0]                      pwm_out
);

    localparam int unsigned NumBytes = C_S_AXI_DATA_WIDTH / 8;
    localparam int unsigned W        = C_PWM_WIDTH;
    // A prescale of 1 still needs a one-bit counter that simply stays at 0.
    localparam int unsigned PreW     = (C_PWM_PRESCALE > 1) ? $clog2(C_PWM_PRESCALE) : 1;
    localparam logic [PreW-1:0] PreLast = PreW'(C_PWM_PRESCALE - 1);

    // Bus state
    logic                          init;
    logic                          aw_full;
    logic [1:0]                    aw_idx;
    logic                          w_full;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_data;
    logic [NumBytes-1:0]           w_strb;
    logic                          bvalid;
    logic                          rvalid;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata;
    logic [C_S_AXI_DATA_WIDTH-1:0] duty [4];
    logic [C_S_AXI_DATA_WIDTH-1:0] wr_word;

    logic aw_hs;
    logic w_hs;
    logic ar_hs;
    logic commit;

    // PWM state
    logic [PreW-1:0] pre;
    logic            tick;
    logic            wrap;
    logic [W-1:0]    cnt;
    logic [W:0]      duty_act [4];

    // Protection bits and the byte offset within a word carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign S_AXI_AWREADY = init & ~aw_full;
    assign S_AXI_WREADY  = init & ~w_full;
    assign S_AXI_ARREADY = init & ~rvalid;
    assign S_AXI_BVALID  = bvalid;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_RVALID  = rvalid;
    assign S_AXI_RDATA   = rdata;
    assign S_AXI_RRESP   = 2'b00;

    assign aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs   = S_AXI_WVALID & S_AXI_WREADY;
    assign ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;
    // A new write only lands once the previous response has been taken.
    assign commit = aw_full & w_full & ~bvalid;

    assign tick = (pre == PreLast);
    assign wrap = tick & (cnt == {W{1'b1}});

    // Hold off all readies until the first edge after reset release.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            init <= 1'b0;
        end else begin
            init <= 1'b1;
        end
    end

    // One-deep write-address slot.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            aw_full <= 1'b0;
            aw_idx  <= 2'b00;
        end else if (commit) begin
            aw_full <= 1'b0;
        end else if (aw_hs) begin
            aw_full <= 1'b1;
            aw_idx  <= S_AXI_AWADDR[3:2];
        end
    end

    // One-deep write-data slot.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            w_full <= 1'b0;
            w_data <= '0;
            w_strb <= '0;
        end else if (commit) begin
            w_full <= 1'b0;
        end else if (w_hs) begin
            w_full <= 1'b1;
            w_data <= S_AXI_WDATA;
            w_strb <= S_AXI_WSTRB;
        end
    end

    // Merge held write data into the addressed register byte by byte.
    always_comb begin
        wr_word = duty[aw_idx];
        for (int b = 0; b < NumBytes; b++) begin
            if (w_strb[b]) begin
                wr_word[8*b +: 8] = w_data[8*b +: 8];
            end
        end
    end

    // Duty register file.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            for (int i = 0; i < 4; i++) begin
                duty[i] <= '0;
            end
        end else if (commit) begin
            duty[aw_idx] <= wr_word;
        end
    end

    // Write response: raised by a commit, dropped when the master accepts it.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            bvalid <= 1'b0;
        end else if (commit) begin
            bvalid <= 1'b1;
        end else if (bvalid && S_AXI_BREADY) begin
            bvalid <= 1'b0;
        end
    end

    // Read channel: registers are sampled before any same-edge commit.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else if (ar_hs) begin
            rvalid <= 1'b1;
            rdata  <= duty[S_AXI_ARADDR[3:2]];
        end else if (rvalid && S_AXI_RREADY) begin
            rvalid <= 1'b0;
        end
    end

    // Prescaler and shared period counter.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            pre <= '0;
            cnt <= '0;
        end else if (tick) begin
            pre <= '0;
            cnt <= cnt + W'(1);
        end else begin
            pre <= pre + PreW'(1);
        end
    end

    // Active duties reload only as the counter wraps to zero.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            for (int i = 0; i < 4; i++) begin
                duty_act[i] <= '0;
            end
        end else if (wrap) begin
            for (int i = 0; i < 4; i++) begin
                duty_act[i] <= duty[i][W:0];
            end
        end
    end

    // Registered compare; the extra duty bit lets 2^W mean "always high".
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            pwm_out <= 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                pwm_out[i] <= ({1'b0, cnt} < duty_act[i]);
            end
        end
    end

endmodule

// File: tb/tb_pwm_4ip_s_axi_slave.sv
// Self-checking bench for pwm_4ip_s_axi_slave (default parameters: W=8, prescale 1).
module tb_pwm_4ip_s_axi_slave;

    logic        clk     = 1'b0;
    logic        aresetn = 1'b0;
    logic [3:0]  awaddr  = '0;
    logic [2:0]  awprot  = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata   = '0;
    logic [3:0]  wstrb   = '0;
    logic        wvalid  = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready  = 1'b0;
    logic [3:0]  araddr  = '0;
    logic [2:0]  arprot  = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready  = 1'b0;
    logic [3:0]  pwm_out;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pwm_4ip_s_axi_slave dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (aresetn),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .pwm_out       (pwm_out)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_init;
    logic [1:0]  aw_q [$];
    logic [35:0] w_q [$];
    logic        m_bvalid;
    logic        m_rvalid;
    logic [31:0] m_rdata;
    logic [31:0] m_duty [4];
    int          m_act [4];
    int          m_k;
    logic [3:0]  m_pwm;
    logic [31:0] pre_duty [4];
    logic [31:0] nw;
    logic [35:0] wd;
    bit          m_awr, m_wr, m_arr, m_commit;

    task automatic m_reset();
        m_init = 0; aw_q.delete(); w_q.delete();
        m_bvalid = 0; m_rvalid = 0; m_rdata = 0; m_k = 0; m_pwm = 0;
        for (int i = 0; i < 4; i++) begin
            m_duty[i] = 0; m_act[i] = 0;
        end
    endtask

    initial m_reset();

    // Model advances at every edge using the inputs present at that edge.
    always @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            m_reset();
        end else begin
            m_awr    = m_init && aw_q.size() == 0;
            m_wr     = m_init && w_q.size() == 0;
            m_arr    = m_init && !m_rvalid;
            m_commit = aw_q.size() == 1 && w_q.size() == 1 && !m_bvalid;
            pre_duty = m_duty;
            if (m_commit) m_bvalid = 1;
            else if (m_bvalid && bready) m_bvalid = 0;
            if (arvalid && m_arr) begin
                m_rdata  = pre_duty[araddr[3:2]];
                m_rvalid = 1;
            end else if (m_rvalid && rready) begin
                m_rvalid = 0;
            end
            if (m_commit) begin
                wd = w_q[0];
                nw = m_duty[aw_q[0]];
                for (int b = 0; b < 4; b++)
                    if (wd[32 + b]) nw[8*b +: 8] = wd[8*b +: 8];
                m_duty[aw_q[0]] = nw;
                aw_q.delete(); w_q.delete();
            end
            if (awvalid && m_awr) aw_q.push_back(awaddr[3:2]);
            if (wvalid && m_wr) w_q.push_back({wstrb, wdata});
            // Edge k sees counter value (k-1) mod 256; wrap edges reload duties.
            m_k++;
            for (int i = 0; i < 4; i++) m_pwm[i] = ((m_k - 1) % 256) < m_act[i];
            if (m_k % 256 == 0)
                for (int i = 0; i < 4; i++) m_act[i] = int'(pre_duty[i] & 32'h1FF);
            m_init = 1;
        end
    end

    // Compare every DUT output against the model on each falling edge.
    always @(negedge clk) begin
        chk("awready", 32'(awready), 32'(m_init && aw_q.size() == 0));
        chk("wready",  32'(wready),  32'(m_init && w_q.size() == 0));
        chk("arready", 32'(arready), 32'(m_init && !m_rvalid));
        chk("bvalid",  32'(bvalid),  32'(m_bvalid));
        chk("bresp",   32'(bresp),   32'(0));
        chk("rvalid",  32'(rvalid),  32'(m_rvalid));
        chk("rdata",   rdata,        m_rdata);
        chk("rresp",   32'(rresp),   32'(0));
        chk("pwm_out", 32'(pwm_out), 32'(m_pwm));
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_aw_w(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly);
        int c = 0;
        bit ad = 0, wdn = 0, ah, wh;
        awaddr = a; wdata = d; wstrb = s;
        while (!(ad && wdn) && c < 60) begin
            awvalid = !ad && c >= aw_dly;
            wvalid  = !wdn && c >= w_dly;
            @(negedge clk);
            if (ad != wdn) chk("no_b_before_both", 32'(bvalid), 32'(0));
            ah = awvalid && awready;
            wh = wvalid && wready;
            step();
            ad |= ah; wdn |= wh; c++;
        end
        awvalid = 0; wvalid = 0;
        chk("aw_w_accepted", 32'({ad, wdn}), 32'(3));
    endtask

    task automatic get_b();
        int c = 0;
        bit got = 0;
        logic [1:0] r = 2'b11;
        bready = 1;
        while (!got && c < 50) begin
            @(negedge clk);
            got = bvalid;
            if (got) r = bresp;
            step();
            c++;
        end
        bready = 0;
        chk("b_seen", 32'(got), 32'(1));
        chk("bresp_okay", 32'(r), 32'(0));
    endtask

    task automatic write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        send_aw_w(a, d, s, 0, 0);
        get_b();
    endtask

    task automatic read(input logic [3:0] a, output logic [31:0] d);
        int c = 0;
        bit h = 0;
        d = 'x;
        araddr = a; arvalid = 1;
        while (!h && c < 50) begin
            @(negedge clk);
            h = arready;
            step();
            c++;
        end
        arvalid = 0;
        chk("ar_accepted", 32'(h), 32'(1));
        h = 0; c = 0; rready = 1;
        while (!h && c < 50) begin
            @(negedge clk);
            h = rvalid;
            if (h) d = rdata;
            step();
            c++;
        end
        rready = 0;
        chk("r_seen", 32'(h), 32'(1));
    endtask

    // ---------------- main sequence ----------------
    logic [31:0] rd;
    int h0, h1, h2, ha, hb;
    bit prev, seen, ah, wh, arh;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_awready", 32'(awready), 32'(0));
        chk("rst_arready", 32'(arready), 32'(0));
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_pwm", 32'(pwm_out), 32'(0));
        aresetn = 1;
        chk("init_gate_awready", 32'(awready), 32'(0));
        step();
        chk("init_awready", 32'(awready), 32'(1));
        chk("init_wready", 32'(wready), 32'(1));
        chk("init_arready", 32'(arready), 32'(1));

        // Basic burst and readback
        for (int i = 0; i < 4; i++) write(4'(4 * i), 32'(i + 1), 4'hF);
        for (int i = 0; i < 4; i++) begin
            read(4'(4 * i), rd);
            chk("readback_1234", rd, 32'(i + 1));
        end

        // AW well before W, then W well before AW
        send_aw_w(4'h8, 32'h0000_0055, 4'hF, 0, 5);
        get_b();
        send_aw_w(4'hC, 32'h0000_0066, 4'hF, 5, 0);
        get_b();
        read(4'h8, rd); chk("aw_first", rd, 32'h55);
        read(4'hC, rd); chk("w_first", rd, 32'h66);

        // Byte strobes, unaligned address
        write(4'h4, 32'hAABB_CCDD, 4'hF);
        write(4'h5, 32'h1122_3344, 4'b0101);
        read(4'h4, rd); chk("wstrb_merge", rd, 32'hAA22_CC44);

        // Back-pressure on B: second write is held until the first response goes
        send_aw_w(4'h8, 32'hCAFE_0001, 4'hF, 0, 0);
        send_aw_w(4'hC, 32'hCAFE_0002, 4'hF, 0, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_bvalid", 32'(bvalid), 32'(1));
            chk("hold_awready", 32'(awready), 32'(0));
            chk("hold_wready", 32'(wready), 32'(0));
            step();
        end
        get_b();
        get_b();
        read(4'hC, rd); chk("held_write2", rd, 32'hCAFE_0002);

        // Back-pressure on R
        araddr = 4'h8; arvalid = 1;
        arh = 0;
        for (int c = 0; c < 50 && !arh; c++) begin
            @(negedge clk); arh = arready; step();
        end
        arvalid = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_rvalid", 32'(rvalid), 32'(1));
            chk("hold_rdata", rdata, 32'hCAFE_0001);
            chk("hold_arready", 32'(arready), 32'(0));
            step();
        end
        rready = 1; step(); rready = 0;

        // PWM duty levels
        write(4'h0, 32'd64, 4'hF);
        write(4'h4, 32'd0, 4'hF);
        write(4'h8, 32'd256, 4'hF);
        repeat (300) step();
        @(negedge clk); prev = pwm_out[0]; seen = 0;
        for (int c = 0; c < 600 && !seen; c++) begin
            @(negedge clk);
            if (pwm_out[0] && !prev) seen = 1;
            prev = pwm_out[0];
        end
        chk("pwm_rise_seen", 32'(seen), 32'(1));
        h0 = 0; h1 = 0; h2 = 0;
        for (int i = 0; i < 256; i++) begin
            if (i > 0) @(negedge clk);
            h0 += int'(pwm_out[0]); h1 += int'(pwm_out[1]); h2 += int'(pwm_out[2]);
        end
        chk("pwm0_duty64", 32'(h0), 32'd64);
        chk("pwm1_duty0", 32'(h1), 32'd0);
        chk("pwm2_duty256", 32'(h2), 32'd256);

        // Mid-period duty change applies only from the next wrap
        ha = 0; hb = 0;
        for (int i = 0; i < 512; i++) begin
            @(negedge clk);
            if (i < 256) ha += int'(pwm_out[0]);
            else hb += int'(pwm_out[0]);
            if (i == 100) begin
                chk("mid_readies", 32'({awready, wready}), 32'(3));
                awaddr = 4'h0; wdata = 32'd128; wstrb = 4'hF;
                awvalid = 1; wvalid = 1; bready = 1;
            end
            if (i == 101) begin awvalid = 0; wvalid = 0; end
            if (i == 110) bready = 0;
        end
        chk("pwm0_old_period", 32'(ha), 32'd64);
        chk("pwm0_new_period", 32'(hb), 32'd128);

        // Reset with a pending AW and an unaccepted read response
        araddr = 4'h4; arvalid = 1;
        @(negedge clk); step(); arvalid = 0;
        awaddr = 4'h0; awvalid = 1;
        @(negedge clk); step(); awvalid = 0;
        #2 aresetn = 0;
        #1;
        chk("arst_awready", 32'(awready), 32'(0));
        chk("arst_wready", 32'(wready), 32'(0));
        chk("arst_arready", 32'(arready), 32'(0));
        chk("arst_bvalid", 32'(bvalid), 32'(0));
        chk("arst_rvalid", 32'(rvalid), 32'(0));
        chk("arst_rdata", rdata, 32'h0);
        chk("arst_pwm", 32'(pwm_out), 32'(0));
        repeat (3) @(negedge clk);
        aresetn = 1;
        chk("rel_awready", 32'(awready), 32'(0));
        step();
        chk("rel_arready", 32'(arready), 32'(1));
        for (int i = 0; i < 4; i++) begin
            read(4'(4 * i), rd);
            chk("post_reset_zero", rd, 32'h0);
        end

        // Randomized traffic with AXI-legal valid holding
        for (int n = 0; n < 3000; n++) begin
            if (!awvalid && $urandom_range(0, 3) == 0) begin
                awvalid = 1; awaddr = 4'($urandom);
            end
            if (!wvalid && $urandom_range(0, 3) == 0) begin
                wvalid = 1; wdata = $urandom; wstrb = 4'($urandom);
                if ($urandom_range(0, 1) == 1) wdata[31:9] = '0;
            end
            if (!arvalid && $urandom_range(0, 2) == 0) begin
                arvalid = 1; araddr = 4'($urandom);
            end
            bready = 1'($urandom_range(0, 1));
            rready = 1'($urandom_range(0, 1));
            @(negedge clk);
            ah = awvalid && awready; wh = wvalid && wready; arh = arvalid && arready;
            step();
            if (ah) awvalid = 0;
            if (wh) wvalid = 0;
            if (arh) arvalid = 0;
        end
        awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
        repeat (10) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
